// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write engine: FSM encoding, LCD command
// bytes and the default timing cycle counts for a 10 MHz clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_CLS    = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;
  localparam logic [7:0] CMD_LINE1  = 8'h80;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] CMD_LINE3  = 8'h94;
  localparam logic [7:0] CMD_LINE4  = 8'hD4;
  localparam logic [7:0] CMD_MODE8  = 8'h38;
  localparam logic [7:0] CMD_ENTRY  = 8'h06;
  localparam logic [7:0] CMD_DISPON = 8'h0E;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_T_SETUP     = 1;
  localparam int DEF_T_EN        = 5;
  localparam int DEF_T_HOLD      = 1;
  localparam int DEF_T_EXEC      = 400;
  localparam int DEF_T_EXEC_LONG = 16000;

  // One buffered entry is {rs, data}.
  localparam int BYTE_W = 9;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long delay.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLS) || (data == CMD_HOME) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Upstream byte handshake into the LCD write engine.
// A byte {in_rs, in_data} transfers on every clk edge where in_valid && in_ready;
// the master holds in_data/in_rs stable while in_valid is high and not yet accepted,
// and in_ready does not depend on in_valid.
interface lcd_write_engine_if;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_rs, output in_valid, input in_ready);
  modport slave  (input in_data, input in_rs, input in_valid, output in_ready);
endinterface

// File: rtl/lcd_byte_fifo.sv
// Small synchronous FIFO of {rs, data} entries; head is visible combinationally.
// No bypass: a push into an empty FIFO is readable only after the push edge.
module lcd_byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lcd_byte_fifo: DEPTH must be a power of two and at least 2");
  end

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 8-bit bus write engine: buffers bytes, then drives setup, enable
// pulse, hold and execution delay for each, pulsing done_tick at the end.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int T_SETUP     = DEF_T_SETUP,
  parameter  int T_EN        = DEF_T_EN,
  parameter  int T_HOLD      = DEF_T_HOLD,
  parameter  int T_EXEC      = DEF_T_EXEC,
  parameter  int T_EXEC_LONG = DEF_T_EXEC_LONG,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  lcd_write_engine_if.slave  up,
  output logic [7:0]         lcd_d,
  output logic               lcd_rs,
  output logic               lcd_en,
  output logic               done_tick,
  output logic               busy,
  output logic [LVL_W-1:0]   level,
  output lcd_state_e         dbg_state
);

  if ((T_SETUP < 1) || (T_EN < 1) || (T_HOLD < 1) || (T_EXEC < 1) || (T_EXEC_LONG < 1))
  begin : g_bad_timing
    $error("lcd_write_engine: every timing parameter must be at least 1");
  end

  // Wide enough for whichever phase is longest, whatever the parameter mix.
  localparam int CNT_W = $clog2(T_SETUP + T_EN + T_HOLD + T_EXEC + T_EXEC_LONG + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        lcd_d_q, lcd_d_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic              long_q, long_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;

  assign up.in_ready = !fifo_full;
  assign fifo_push   = up.in_valid && !fifo_full;

  lcd_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({up.in_rs, up.in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Each timed state ends when the counter reads 1, loading the next phase length.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lcd_d_d  = lcd_d_q;
    lcd_rs_d = lcd_rs_q;
    long_d   = long_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          lcd_d_d  = fifo_head[7:0];
          lcd_rs_d = fifo_head[8];
          long_d   = is_long_cmd(fifo_head[8], fifo_head[7:0]);
          cnt_d    = CNT_W'(T_SETUP);
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_W'(T_EN);
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_W'(T_HOLD);
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = long_q ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lcd_d_q  <= 8'h00;
      lcd_rs_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcd_d_q  <= lcd_d_d;
      lcd_rs_q <= lcd_rs_d;
      long_q   <= long_d;
    end
  end

  // lcd_en decodes straight from the state flop so reset drops it at once.
  assign lcd_en    = (state_q == ST_PULSE);
  assign done_tick = (state_q == ST_EXEC) && (cnt_q == CNT_ONE);
  assign lcd_d     = lcd_d_q;
  assign lcd_rs    = lcd_rs_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign level     = fifo_level;
  assign dbg_state = state_q;

endmodule
